// File: rtl/cdc_fifo_read_state.sv
// Read-side pointer/state block of the dual-clock FIFO: synchronises the write pointer, detects empty,
// fetches from the RAM and presents first-word-fall-through data through a 2-entry skid buffer.
module cdc_fifo_read_state #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] write_address_gray,
  input  logic [DATA_WIDTH-1:0]    ram_read_data,
  input  logic                     read_ready,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [ADDRESS_WIDTH-1:0] read_address_gray,
  output logic                     empty,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid
);

  logic [ADDRESS_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [ADDRESS_WIDTH-1:0] write_sync;
  logic [ADDRESS_WIDTH-1:0] read_address_reg;
  logic [ADDRESS_WIDTH-1:0] read_address_gray_reg;
  logic [ADDRESS_WIDTH-1:0] read_address_next;
  logic [ADDRESS_WIDTH-1:0] read_address_gray_next;
  logic [DATA_WIDTH-1:0]    buffer_reg [2];
  logic                     head_reg;
  logic                     tail;
  logic [1:0]               count_reg;
  logic [1:0]               count_next;
  logic                     inflight_reg;
  logic                     pop;
  logic [2:0]               occupancy;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_reg[gi] <= '0;
        else       sync_reg[gi] <= write_address_gray;
      end
    end else begin : g_next
      always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_reg[gi] <= '0;
        else       sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < ADDRESS_WIDTH; gi++) begin : g_gray2bin
    assign write_sync[gi] = ^sync_reg[SYNC_STAGES-1][ADDRESS_WIDTH-1:gi];
  end

  assign empty      = (read_address_reg == write_sync);
  assign data_valid = (count_reg != 2'd0);
  assign pop        = data_valid & read_ready;
  assign data_out   = buffer_reg[head_reg];
  assign tail       = head_reg ^ count_reg[0];

  // Words held plus the word on its way, after this cycle's pop; fetch only if it still fits.
  assign occupancy       = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign ram_read_enable = !empty && (occupancy < 3'd2);
  assign count_next      = count_reg + {1'b0, inflight_reg} - {1'b0, pop};

  assign read_address_next      = read_address_reg + ADDRESS_WIDTH'(1);
  assign read_address_gray_next = read_address_next ^ (read_address_next >> 1);
  assign read_address           = read_address_reg;
  assign read_address_gray      = read_address_gray_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_address_reg      <= '0;
      read_address_gray_reg <= '0;
      inflight_reg          <= 1'b0;
      head_reg              <= 1'b0;
      count_reg             <= 2'd0;
      buffer_reg[0]         <= '0;
      buffer_reg[1]         <= '0;
    end else begin
      inflight_reg <= ram_read_enable;
      if (ram_read_enable) begin
        read_address_reg      <= read_address_next;
        read_address_gray_reg <= read_address_gray_next;
      end
      if (inflight_reg) buffer_reg[tail] <= ram_read_data;
      if (pop)          head_reg <= ~head_reg;
      count_reg <= count_next;
    end
  end

  assert property (@(posedge clock) disable iff (reset) count_reg <= 2'd2);
  assert property (@(posedge clock) disable iff (reset) !(inflight_reg && count_reg == 2'd2 && !pop));
  assert property (@(posedge clock) disable iff (reset) ram_read_enable |-> !empty);

endmodule

// File: tb/tb_cdc_fifo_read_state.sv
// Bench for cdc_fifo_read_state: emulates the RAM and write side, and checks the read stream
// against a queue of written words plus the address/Gray/empty behaviour.
module tb_cdc_fifo_read_state;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] write_address_gray;
  logic [7:0] ram_read_data;
  logic       read_ready;
  logic       ram_read_enable;
  logic [3:0] read_address;
  logic [3:0] read_address_gray;
  logic       empty;
  logic [7:0] data_out;
  logic       data_valid;

  cdc_fifo_read_state #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock              (clock),
    .reset              (reset),
    .write_address_gray (write_address_gray),
    .ram_read_data      (ram_read_data),
    .read_ready         (read_ready),
    .ram_read_enable    (ram_read_enable),
    .read_address       (read_address),
    .read_address_gray  (read_address_gray),
    .empty              (empty),
    .data_out           (data_out),
    .data_valid         (data_valid)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem [16];
  logic [3:0]  wp;
  logic [3:0]  fp;
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int enables = 0;
  int first_pop = -1;
  int last_pop = -1;

  // Synchronous-read RAM with one cycle of latency.
  always @(posedge clock) begin
    if (ram_read_enable) ram_read_data <= mem[read_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wp] = d;
    exp_q.push_back(32'(d));
    wp = wp + 4'd1;
    write_address_gray = wp ^ (wp >> 1);
  endtask

  // One clock: account for the pop and fetch about to happen, then advance past the edge.
  task automatic tick();
    #1;
    if (data_valid && read_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(data_valid), 32'd0);
      else chk("pop_data", 32'(data_out), exp_q.pop_front());
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (ram_read_enable) begin
      chk("fetch_addr", 32'(read_address), 32'(fp));
      chk("fetch_not_empty", 32'(empty), 32'd0);
      fp = fp + 4'd1;
      enables++;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read_ready = 1'b0;
    wp = 4'd0;
    fp = 4'd0;
    write_address_gray = 4'd0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    pops = 0;
    enables = 0;
    first_pop = -1;
    last_pop = -1;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // 1: reset with arbitrary inputs
    reset = 1'b1;
    write_address_gray = 4'($urandom);
    read_ready = 1'($urandom);
    wp = 4'd0;
    fp = 4'd0;
    #12;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_addr", 32'(read_address), 32'd0);
    chk("rst_gray", 32'(read_address_gray), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    do_reset();

    // 2: single word latency
    push_word(8'hA5);
    tick();
    chk("t2_empty_1edge", 32'(empty), 32'd1);
    tick();
    chk("t2_empty_2edge", 32'(empty), 32'd0);
    chk("t2_enable", 32'(ram_read_enable), 32'd1);
    chk("t2_addr0", 32'(read_address), 32'd0);
    tick();
    chk("t2_gray", 32'(read_address_gray), 32'b0001);
    chk("t2_empty_after", 32'(empty), 32'd1);
    chk("t2_valid_early", 32'(data_valid), 32'd0);
    tick();
    chk("t2_valid", 32'(data_valid), 32'd1);
    chk("t2_data", 32'(data_out), 32'hA5);
    read_ready = 1'b1;
    tick();
    chk("t2_valid_after_pop", 32'(data_valid), 32'd0);
    chk("t2_pops", 32'(pops), 32'd1);

    // 3: fifteen words at full rate
    do_reset();
    for (int i = 0; i < 15; i++) push_word(8'($urandom));
    read_ready = 1'b1;
    for (int n = 0; n < 40 && pops < 15; n++) tick();
    chk("t3_pops", 32'(pops), 32'd15);
    chk("t3_rate", 32'(last_pop - first_pop), 32'd14);
    chk("t3_enables", 32'(enables), 32'd15);
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_addr", 32'(read_address), 32'd15);

    // 4: back-pressure stalls fetching after two words
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'(8'h30 + i));
    for (int n = 0; n < 12; n++) tick();
    chk("t4_enables", 32'(enables), 32'd2);
    chk("t4_enable_off", 32'(ram_read_enable), 32'd0);
    chk("t4_valid", 32'(data_valid), 32'd1);
    chk("t4_head", 32'(data_out), 32'h30);
    read_ready = 1'b1;
    drain(30);
    chk("t4_pops", 32'(pops), 32'd5);

    // 5: pointer wrap
    do_reset();
    for (int i = 0; i < 14; i++) push_word(8'($urandom));
    read_ready = 1'b1;
    drain(40);
    for (int n = 0; n < 3; n++) tick();
    chk("t5_addr14", 32'(read_address), 32'd14);
    chk("t5_gray14", 32'(read_address_gray), 32'b1001);
    chk("t5_empty14", 32'(empty), 32'd1);
    push_word(8'hE1);
    for (int n = 0; n < 4; n++) tick();
    chk("t5_addr15", 32'(read_address), 32'd15);
    chk("t5_gray15", 32'(read_address_gray), 32'b1000);
    chk("t5_empty15", 32'(empty), 32'd1);
    push_word(8'hE2);
    for (int n = 0; n < 4; n++) tick();
    chk("t5_addr0", 32'(read_address), 32'd0);
    chk("t5_gray0", 32'(read_address_gray), 32'b0000);
    chk("t5_empty0", 32'(empty), 32'd1);
    push_word(8'hE3);
    for (int n = 0; n < 4; n++) tick();
    chk("t5_addr1", 32'(read_address), 32'd1);
    chk("t5_gray1", 32'(read_address_gray), 32'b0001);
    drain(10);

    // 6: asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i));
    for (int n = 0; n < 20 && !data_valid; n++) tick();
    chk("t6_valid_before", 32'(data_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_valid", 32'(data_valid), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_addr", 32'(read_address), 32'd0);
    chk("t6_gray", 32'(read_address_gray), 32'd0);
    chk("t6_data", 32'(data_out), 32'd0);
    do_reset();
    for (int n = 0; n < 3; n++) tick();
    chk("t6_valid_after", 32'(data_valid), 32'd0);
    for (int i = 0; i < 3; i++) push_word(8'(8'h70 + i));
    read_ready = 1'b1;
    drain(20);
    chk("t6_pops", 32'(pops), 32'd3);

    // 7: random writes and back-pressure
    do_reset();
    for (int n = 0; n < 400; n++) begin
      read_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 && (wp + 4'd1) != read_address) push_word(8'($urandom));
      tick();
    end
    read_ready = 1'b1;
    drain(100);
    for (int n = 0; n < 3; n++) tick();
    chk("t7_empty", 32'(empty), 32'd1);
    chk("t7_valid", 32'(data_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
